// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared state codes, forwarding codes and constants for the
//                MIPS pipeline hazard/stall controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Controller FSM state codes; code 2'b11 is unreachable.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  // EX-stage ALU operand source selects.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Register $zero is never a real hazard or forwarding source.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Combinational EX-stage forwarding select for one ALU operand.
//                The younger EX/MEM result always wins over MEM/WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_dest,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_dest,
  output logic [1:0] fwd_sel
);

  // Priority select: EX/MEM first, then MEM/WB, else register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_regwrite && (exmem_dest != REG_ZERO) && (exmem_dest == ex_src)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_dest != REG_ZERO) && (memwb_dest == ex_src)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard/stall controller for a 5-stage MIPS pipeline: stage
//                enables, flushes, MEM/WB bubble, forwarding selects and a
//                data-memory wait FSM with timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_dest,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_dest,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_dest,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err,
  output logic [1:0]       state
);

  // Wait counter is wide enough for the largest legal TIMEOUT (65535).
  localparam int WAIT_W = 16;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               mem_err_q, mem_err_d;
  logic               load_use;
  logic [1:0]         fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd_a (
    .ex_src         (ex_rs),
    .exmem_regwrite (exmem_regwrite),
    .exmem_dest     (exmem_dest),
    .memwb_regwrite (memwb_regwrite),
    .memwb_dest     (memwb_dest),
    .fwd_sel        (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .ex_src         (ex_rt),
    .exmem_regwrite (exmem_regwrite),
    .exmem_dest     (exmem_dest),
    .memwb_regwrite (memwb_regwrite),
    .memwb_dest     (memwb_dest),
    .fwd_sel        (fwd_b_raw)
  );

  // Load in ID/EX whose destination is read by the instruction in ID.
  assign load_use = idex_memread && (idex_dest != REG_ZERO) &&
                    ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));

  // Next-state, counter updates and pipeline controls from state and inputs.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          // Freeze everything up to EX/MEM; a pending redirect in EX waits.
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_d       = WAIT_W'(1);
        end else if (ex_branch_taken || ex_jump) begin
          // Squash the wrong-path instructions in IF/ID and ID/EX.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID for one cycle, inject a bubble into ID/EX.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        if (mem_ack || !mem_req) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q >= WAIT_W'(TIMEOUT)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        mem_err_d    = 1'b1;
      end
      default: begin
        // Illegal code: hold the pipeline this cycle and recover to RUN.
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        state_d      = ST_RUN;
        wait_d       = '0;
      end
    endcase

    // Reset forces a safe, fully squashed pipeline.
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_en      = 1'b0;
      idex_flush   = 1'b1;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State, wait counter, stall counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign stall_count = stall_q;
  assign mem_err     = mem_err_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and stall controller for the 5-stage MIPS pipeline. It drives enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates EX-stage forwarding selects. It also runs a data-memory request/acknowledge wait state machine with a timeout. It sits beside the datapath and observes only decoded fields, never 32-bit data.

Parameters:
TIMEOUT, 16, max cycles MEM_WAIT may last without mem_ack before the controller enters ERR; legal range 2..65535.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
idex_memread  in  1  ID/EX stage holds a load
idex_dest  in  5  ID/EX destination register
ex_rs  in  5  rs of the instruction in EX
ex_rt  in  5  rt of the instruction in EX
ex_branch_taken  in  1  taken branch resolved in EX
ex_jump  in  1  jump resolved in EX
exmem_regwrite  in  1  EX/MEM RegWrite
exmem_dest  in  5  EX/MEM destination register
memwb_regwrite  in  1  MEM/WB RegWrite
memwb_dest  in  5  MEM/WB destination register
mem_req  in  1  EX/MEM stage holds a memory access
mem_ack  in  1  data memory completion, 1-cycle pulse
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX clear, all control bits 0
exmem_en  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB loads zero control bits (RegWrite, Jump, MemtoReg all 0)
fwd_a  out  2  ALU operand A source: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
fwd_b  out  2  ALU operand B source, same encoding as fwd_a
stall_count  out  CNT_W  saturating count of cycles with pc_en = 0
mem_err  out  1  sticky memory-timeout flag
state  out  2  FSM state code

Behaviour:
- The clock port is clk. Reset port rst is asynchronous and active-high.
- While rst is high:
  - state = RUN (00), stall_count = 0, wait counter = 0, mem_err = 0.
  - Enables are forced to 0, ifid_flush and idex_flush to 1, memwb_bubble to 1, fwd_a/fwd_b to 00.
- FSM states: RUN = 00, MEM_WAIT = 01, ERR = 10. Code 11 is unreachable; if it occurs, return to RUN on the next edge.
- Control outputs are combinational from state and current inputs. Only the state, counters and mem_err are registered.
- RUN, rules applied in priority order:
  1. mem_req = 1 and mem_ack = 0:
     - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1.
     - Next state MEM_WAIT; wait counter loads 1.
     - A branch or jump in EX is not acted on in this cycle. EX is frozen, so the redirect is re-presented later.
  2. ex_branch_taken or ex_jump = 1:
     - ifid_flush = 1, idex_flush = 1, all enables = 1.
     - Load-use detection is suppressed, because the ID instruction is being squashed.
  3. Load-use hazard: idex_memread = 1, idex_dest != 0, and (idex_dest == id_rs, or id_uses_rt = 1 and idex_dest == id_rt).
     - pc_en = 0, ifid_en = 0, idex_flush = 1; exmem_en = 1.
     - Exactly one bubble per hazard. The following cycle re-evaluates the hazard.
  4. Otherwise: all enables = 1, all flushes and the bubble = 0.
- mem_req = 1 with mem_ack = 1 in the same RUN cycle is a zero-wait access: no stall.
- MEM_WAIT:
  - Outputs are the same as RUN rule 1.
  - When mem_ack = 1: next state RUN, wait counter cleared. The release cycle itself still has enables = 0, so the pipeline resumes on the following edge.
  - When the wait counter reaches TIMEOUT without mem_ack: next state ERR, mem_err set to 1.
  - Otherwise the wait counter increments.
  - mem_req dropping while in MEM_WAIT is treated as ack.
- ERR:
  - All enables = 0; memwb_bubble = 1; mem_err = 1.
  - Only rst exits ERR.
- Forwarding (fwd_a; fwd_b identical using ex_rt):
  - 10 when exmem_regwrite = 1, exmem_dest != 0 and exmem_dest == ex_rs.
  - Otherwise 01 when memwb_regwrite = 1, memwb_dest != 0 and memwb_dest == ex_rs.
  - Otherwise 00.
  - EX/MEM always wins over MEM/WB.
- stall_count increments on every edge where pc_en = 0 and rst = 0, including ERR. It saturates at all-ones.
- Reset mid-MEM_WAIT aborts the wait and discards the outstanding access.

Decomposition:
- Shared package pipe_pkg holds:
  - state codes ST_RUN, ST_MEM_WAIT, ST_ERR;
  - forwarding codes FWD_RF, FWD_MEMWB, FWD_EXMEM;
  - REG_ZERO = 5'd0.
- One sub-module, fwd_unit: purely combinational forwarding select, instantiated once per operand.
- Everything else stays in pipeline_ctrl.

Test Plan:
1. Load-use: idex_memread = 1, idex_dest = 8, id_rs = 8 -> pc_en = 0, ifid_en = 0, idex_flush = 1 for exactly 1 cycle; stall_count goes 0 -> 1.
2. Load-use with idex_dest = 0 and id_rs = 0 -> no stall, all enables 1.
3. Forwarding: exmem_regwrite = 1, exmem_dest = 5, memwb_regwrite = 1, memwb_dest = 5, ex_rs = 5 -> fwd_a = 10. With exmem_regwrite = 0 -> fwd_a = 01.
4. Memory wait: mem_req = 1, mem_ack arrives 3 cycles later -> MEM_WAIT for 3 cycles, enables 0 and memwb_bubble = 1 through the ack cycle, RUN afterwards, stall_count = 4.
5. Timeout with TIMEOUT = 4: mem_req = 1 and mem_ack never asserted -> ERR after 4 cycles, mem_err = 1 and stays 1. Asserting rst -> RUN, mem_err = 0, stall_count = 0.
6. Branch during stall: ex_branch_taken = 1 with mem_req = 1 and mem_ack = 0 -> no flush. After mem_ack, the next cycle gives ifid_flush = 1 and idex_flush = 1; a simultaneous load-use hazard is ignored.
